// File: rtl/kairo_muldiv_seq.sv
// Sequential RISC-V M-extension unit: multi-cycle multiply and 32-step restoring divide.
// Optional macro KAIRO_DIV_FAST_EXC_EN sends divide-by-zero and signed overflow straight to DONE.
module kairo_muldiv_seq #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        KILL,
  input  logic        INST_MUL,
  input  logic        INST_MULH,
  input  logic        INST_MULHSU,
  input  logic        INST_MULHU,
  input  logic        INST_DIV,
  input  logic        INST_DIVU,
  input  logic        INST_REM,
  input  logic        INST_REMU,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  output logic        STALL,
  output logic        BUSY,
  output logic        VALID,
  output logic [31:0] RESULT
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;

  // Op index: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  logic [7:0] op_in;
  logic [2:0] op_idx;
  logic       accept;
  logic       in_div;
  logic       in_signed_div;

  assign op_in = {INST_REMU, INST_REM, INST_DIVU, INST_DIV,
                  INST_MULHU, INST_MULHSU, INST_MULH, INST_MUL};

  always_comb begin
    op_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (op_in[i]) op_idx = 3'(i);
    end
  end

  assign accept        = START && !KILL && $onehot(op_in) &&
                         (state == S_IDLE || state == S_DONE);
  assign in_div        = |op_in[7:4];
  assign in_signed_div = op_in[4] | op_in[6];

  logic        fast_exc;
  logic [31:0] fast_result;
`ifdef KAIRO_DIV_FAST_EXC_EN
  logic div_zero_in;
  logic ovf_in;
  logic in_rem;
  assign in_rem      = op_in[6] | op_in[7];
  assign div_zero_in = (RS2 == '0);
  assign ovf_in      = in_signed_div && (RS1 == 32'h8000_0000) && (RS2 == 32'hFFFF_FFFF);
  assign fast_exc    = in_div && (div_zero_in || ovf_in);
  assign fast_result = div_zero_in ? (in_rem ? RS1 : 32'hFFFF_FFFF)
                                   : (in_rem ? 32'h0 : 32'h8000_0000);
`else
  assign fast_exc    = 1'b0;
  assign fast_result = '0;
`endif

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [63:0] prod;
  logic [31:0]        mul_out;

  assign a_ext   = {((op_q == 3'd1) || (op_q == 3'd2)) & a_q[31], a_q};
  assign b_ext   = {(op_q == 3'd1) & b_q[31], b_q};
  assign prod    = a_ext * b_ext;
  assign mul_out = (op_q == 3'd0) ? prod[31:0] : prod[63:32];

  logic        sdiv_q;
  logic        rem_sel;
  logic [31:0] dvs;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_sub;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] div_out;

  assign sdiv_q  = op_q[2] & ~op_q[0];
  assign rem_sel = op_q[2] & op_q[1];
  assign dvs     = (sdiv_q && b_q[31]) ? -b_q : b_q;
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, dvs};
  assign rem_sub = shifted[31:0] - dvs;

  // Zero divisor bypasses sign correction; signed overflow falls out of the magnitude path.
  always_comb begin
    q_fix = quo_q;
    r_fix = rem_q;
    if (b_q == '0) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = a_q;
    end else begin
      if (sdiv_q && (a_q[31] ^ b_q[31])) q_fix = -quo_q;
      if (sdiv_q && a_q[31])             r_fix = -rem_q;
    end
  end

  assign div_out = rem_sel ? r_fix : q_fix;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (KILL) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          if (accept) begin
            a_q  <= RS1;
            b_q  <= RS2;
            op_q <= op_idx;
            if (fast_exc) begin
              state    <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= fast_result;
            end else if (in_div) begin
              state  <= S_DIV;
              busy_q <= 1'b1;
              cnt    <= 5'd31;
              rem_q  <= '0;
              quo_q  <= (in_signed_div && RS1[31]) ? -RS1 : RS1;
            end else begin
              state  <= S_MUL;
              busy_q <= 1'b1;
              cnt    <= 5'(MUL_LATENCY - 1);
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            state    <= S_DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            result_q <= mul_out;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DIV: begin
          rem_q <= ge ? rem_sub : shifted[31:0];
          quo_q <= {quo_q[30:0], ge};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 5'd1;
        end
        S_FIX: begin
          state    <= S_DONE;
          busy_q   <= 1'b0;
          valid_q  <= 1'b1;
          result_q <= div_out;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign STALL  = RST_N & (busy_q | accept);
  assign BUSY   = busy_q;
  assign VALID  = valid_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_kairo_muldiv_seq.sv
// Directed self-checking bench for kairo_muldiv_seq with MUL_LATENCY=2.
// Expected divide-exception latency follows KAIRO_DIV_FAST_EXC_EN.
module tb_kairo_muldiv_seq;

  localparam int MUL_LAT = 2;
`ifdef KAIRO_DIV_FAST_EXC_EN
  localparam int EXC_LAT = 1;
`else
  localparam int EXC_LAT = 34;
`endif

  localparam logic [7:0] OP_MUL    = 8'b0000_0001;
  localparam logic [7:0] OP_MULH   = 8'b0000_0010;
  localparam logic [7:0] OP_MULHSU = 8'b0000_0100;
  localparam logic [7:0] OP_MULHU  = 8'b0000_1000;
  localparam logic [7:0] OP_DIV    = 8'b0001_0000;
  localparam logic [7:0] OP_DIVU   = 8'b0010_0000;
  localparam logic [7:0] OP_REM    = 8'b0100_0000;
  localparam logic [7:0] OP_REMU   = 8'b1000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [7:0]  ops;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  kairo_muldiv_seq #(.MUL_LATENCY(MUL_LAT)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .KILL(kill),
    .INST_MUL(ops[0]), .INST_MULH(ops[1]), .INST_MULHSU(ops[2]), .INST_MULHU(ops[3]),
    .INST_DIV(ops[4]), .INST_DIVU(ops[5]), .INST_REM(ops[6]), .INST_REMU(ops[7]),
    .RS1(rs1), .RS2(rs2), .STALL(stall), .BUSY(busy), .VALID(valid), .RESULT(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the request across one rising edge, then clears it.
  task automatic applyStimulus(input logic [7:0] op_v, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    ops   = op_v;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    ops   = '0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid && lat < 100);
  endtask

  task automatic runOp(input string tag, input logic [7:0] op_v, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    applyStimulus(op_v, a, b);
    checkOutput({tag, "_busy"}, {31'b0, busy}, {31'b0, exp_lat > 1});
    waitValid(lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_res"}, result, exp_res);
    checkOutput({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
  endtask

  task automatic watchNoValid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    checkOutput(tag, seen, 32'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    ops   = '0;
    rs1   = '0;
    rs2   = '0;
    #1 rst_n = 1'b0;
    start = 1'b1;
    ops   = OP_MUL;
    #2;
    checkOutput("rst_busy",   {31'b0, busy},  32'd0);
    checkOutput("rst_valid",  {31'b0, valid}, 32'd0);
    checkOutput("rst_result", result,         32'd0);
    checkOutput("rst_stall",  {31'b0, stall}, 32'd0);
    start = 1'b0;
    ops   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start = 1'b1;
    ops   = OP_MULH;
    #1;
    checkOutput("idle_accept_stall", {31'b0, stall}, 32'd1);
    runOp("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT + 1, 32'h0000_0000);
    @(negedge clk);
    runOp("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT + 1, 32'hFFFF_FFFE);
    @(negedge clk);
    runOp("mul",    OP_MUL,    32'd7,         32'd6,         MUL_LAT + 1, 32'd42);
    @(negedge clk);
    runOp("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         MUL_LAT + 1, 32'hFFFF_FFFF);
    @(negedge clk);
    runOp("div_neg", OP_DIV,   32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFD);
    @(negedge clk);
    runOp("rem_neg", OP_REM,   32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF);
    @(negedge clk);
    runOp("divu",   OP_DIVU,   32'd100,       32'd7,         34, 32'd14);
    @(negedge clk);
    runOp("remu",   OP_REMU,   32'd100,       32'd7,         34, 32'd2);
    repeat (3) @(negedge clk);
    checkOutput("hold_result", result, 32'd2);
    checkOutput("hold_valid",  {31'b0, valid}, 32'd0);

    runOp("divu_z", OP_DIVU, 32'h1234_5678, 32'd0, EXC_LAT, 32'hFFFF_FFFF);
    @(negedge clk);
    runOp("remu_z", OP_REMU, 32'h1234_5678, 32'd0, EXC_LAT, 32'h1234_5678);
    @(negedge clk);
    runOp("div_z",  OP_DIV,  32'hFFFF_FFF9, 32'd0, EXC_LAT, 32'hFFFF_FFFF);
    @(negedge clk);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, EXC_LAT, 32'h8000_0000);
    @(negedge clk);
    runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, EXC_LAT, 32'h0000_0000);
    @(negedge clk);

    // Kill a divide part-way through its iterations.
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    checkOutput("kill_busy",  {31'b0, busy},  32'd0);
    checkOutput("kill_stall", {31'b0, stall}, 32'd0);
    watchNoValid("kill_no_valid", 40);
    checkOutput("kill_result_held", result, 32'h0000_0000);

    start = 1'b1;
    kill  = 1'b1;
    ops   = OP_MUL;
    rs1   = 32'd3;
    rs2   = 32'd3;
    #1;
    checkOutput("startkill_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    ops   = '0;
    watchNoValid("startkill_ignored", 6);

    start = 1'b1;
    ops   = OP_MUL | OP_DIV;
    #1;
    checkOutput("multi_op_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    ops   = '0;
    watchNoValid("multi_op_ignored", 6);

    // Back-to-back: second request issued in the DONE cycle of the first.
    runOp("b2b_first", OP_MUL, 32'd3, 32'd5, MUL_LAT + 1, 32'd15);
    start = 1'b1;
    ops   = OP_MUL;
    rs1   = 32'd4;
    rs2   = 32'd5;
    #1;
    checkOutput("b2b_done_stall", {31'b0, stall}, 32'd1);
    applyStimulus(OP_MUL, 32'd4, 32'd5);
    waitValid(lat);
    checkOutput("b2b_lat", lat, MUL_LAT + 1);
    checkOutput("b2b_res", result, 32'd20);
    @(negedge clk);

    applyStimulus(OP_MUL, 32'd9, 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",   {31'b0, busy},  32'd0);
    checkOutput("midrst_valid",  {31'b0, valid}, 32'd0);
    checkOutput("midrst_result", result,         32'd0);
    checkOutput("midrst_stall",  {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watchNoValid("midrst_no_valid", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
